mac_seq_ctrl: RTL and testbench

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

---
 rtl/mac_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// Sequencer that feeds operand beats into an external 16-bit MAC and returns one sum per job.
// Optional overflow saturation/flag is enabled with `define MAC_SEQ_CTRL_OVF_EN.
module mac_seq_ctrl #(
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             mac_en,
    output logic [7:0]       mac_a,
    output logic [7:0]       mac_b,
    input  logic [15:0]      mac_c,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             res_ovf,
    output logic             busy
);

    localparam int unsigned CNT_W = LEN_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             beat;
    logic             job_load;

    assign beat     = in_valid && (state == RUN);
    assign job_load = (state == IDLE) && start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus state-decoded handshake and MAC drive
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mac_en    = 1'b0;
        mac_a     = 8'h00;
        mac_b     = 8'h00;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                mac_en   = 1'b1;
                if (in_valid) begin
                    mac_a = in_a;
                    mac_b = in_b;
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                mac_en    = 1'b1;
                state_nxt = RESULT;
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Remaining-beat counter; len of zero means a full 2^LEN_W beats
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (job_load) begin
            cnt <= (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
        end else if (beat) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

`ifdef MAC_SEQ_CTRL_OVF_EN
    logic [15:0] prev_sum;
    logic        ovf;
    logic        ovf_c;

    // A running sum that drops below its previous value has wrapped
    assign ovf_c = ovf || (mac_c < prev_sum);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_sum <= '0;
            ovf      <= 1'b0;
        end else if (job_load) begin
            prev_sum <= '0;
            ovf      <= 1'b0;
        end else if ((state == RUN) || (state == DRAIN)) begin
            prev_sum <= mac_c;
            ovf      <= ovf_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_data <= '0;
            res_ovf  <= 1'b0;
        end else if (state == DRAIN) begin
            res_data <= ovf_c ? 16'hFFFF : mac_c;
            res_ovf  <= ovf_c;
        end else if ((state == RESULT) && res_ready) begin
            res_ovf  <= 1'b0;
        end
    end
`else
    assign res_ovf = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_data <= '0;
        end else if (state == DRAIN) begin
            res_data <= mac_c;
        end
    end
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl with a behavioural accumulating MAC attached.
module tb_mac_seq_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [3:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        mac_en;
    logic [7:0]  mac_a;
    logic [7:0]  mac_b;
    logic [15:0] mac_c;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_ovf;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    logic [16:0] exp_q[$];
    logic [7:0]  beat_a[16];
    logic [7:0]  beat_b[16];
    logic [15:0] acc = 16'h0000;

    mac_seq_ctrl #(.LEN_W(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mac_en    (mac_en),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_c     (mac_c),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_ovf   (res_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External MAC: accumulates while enabled, clears when disabled
    always @(posedge clk) begin
        if (mac_en) acc <= acc + (16'(mac_a) * 16'(mac_b));
        else        acc <= 16'h0000;
    end
    assign mac_c = acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Result monitor: pops an expectation for every accepted result
    initial begin
        forever begin
            @(negedge clk);
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", {15'd0, res_ovf, res_data}, 32'hDEAD);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    chk("res_data", 32'(res_data), 32'(e[15:0]));
                    chk("res_ovf", 32'(res_ovf), 32'(e[16]));
                end
            end
        end
    end

    task automatic send_job(input logic [3:0] len_v, input int nbeats, input int gap);
        @(posedge clk); #1;
        start = 1'b1;
        len   = len_v;
        @(posedge clk); #1;
        start = 1'b0;
        chk("in_ready_run", 32'(in_ready), 32'd1);
        for (int b = 0; b < nbeats; b++) begin
            in_valid = 1'b1;
            in_a     = beat_a[b];
            in_b     = beat_b[b];
            @(posedge clk); #1;
            chk("mac_en_beat", 32'(mac_en), 32'd1);
            in_valid = 1'b0;
            in_a     = 8'h00;
            in_b     = 8'h00;
            if (b != nbeats - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                    chk("mac_en_gap", 32'(mac_en), 32'd1);
                end
            end
        end
    endtask

    // Last beat's edge -> DRAIN visible, then res_valid on the following cycle
    task automatic check_drain_latency();
        @(negedge clk);
        chk("drain_res_valid", 32'(res_valid), 32'd0);
        chk("drain_in_ready", 32'(in_ready), 32'd0);
        chk("drain_mac_en", 32'(mac_en), 32'd1);
        chk("drain_mac_a", 32'(mac_a), 32'd0);
        @(negedge clk);
        chk("result_res_valid", 32'(res_valid), 32'd1);
        chk("result_mac_en", 32'(mac_en), 32'd0);
    endtask

    task automatic wait_result();
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        if (!seen) chk("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) chk("scoreboard_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        len       = 4'd0;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        res_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mac_en", 32'(mac_en), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        reset_n = 1'b1;

        // Three back-to-back beats: 6+20+42 = 0x44
        beat_a[0] = 8'd2; beat_b[0] = 8'd3;
        beat_a[1] = 8'd4; beat_b[1] = 8'd5;
        beat_a[2] = 8'd6; beat_b[2] = 8'd7;
        exp_q.push_back({1'b0, 16'h0044});
        send_job(4'd3, 3, 0);
        check_drain_latency();
        wait_drain();

        // Same job with two idle cycles between beats
        exp_q.push_back({1'b0, 16'h0044});
        send_job(4'd3, 3, 2);
        check_drain_latency();
        wait_drain();

        // Full-length job of maximum operands wraps the 16-bit sum
        for (int i = 0; i < 16; i++) begin
            beat_a[i] = 8'd255;
            beat_b[i] = 8'd255;
        end
`ifdef MAC_SEQ_CTRL_OVF_EN
        exp_q.push_back({1'b1, 16'hFFFF});
`else
        exp_q.push_back({1'b0, 16'hE010});
`endif
        send_job(4'd0, 16, 0);
        check_drain_latency();
        wait_drain();

        // Backpressured result; a start pulse in RESULT must be ignored
        res_ready = 1'b0;
        beat_a[0] = 8'd5; beat_b[0] = 8'd6;
        exp_q.push_back({1'b0, 16'h001E});
        send_job(4'd1, 1, 0);
        wait_result();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            start = (i == 1);
            len   = 4'd2;
            @(negedge clk);
            chk("hold_res_valid", 32'(res_valid), 32'd1);
            chk("hold_res_data", 32'(res_data), 32'h001E);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_mac_en", 32'(mac_en), 32'd0);
        end
        @(posedge clk); #1;
        start     = 1'b0;
        res_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        chk("idle_after_hold_busy", 32'(busy), 32'd0);
        chk("idle_after_hold_mac_en", 32'(mac_en), 32'd0);

        // Reset mid-job discards it; outputs return to reset values at once
        beat_a[0] = 8'd9; beat_b[0] = 8'd9;
        beat_a[1] = 8'd8; beat_b[1] = 8'd8;
        send_job(4'd4, 2, 0);
        in_valid = 1'b1;
        in_a     = 8'd7;
        in_b     = 8'd7;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_mac_en", 32'(mac_en), 32'd0);
        chk("mid_rst_mac_a", 32'(mac_a), 32'd0);
        chk("mid_rst_mac_b", 32'(mac_b), 32'd0);
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_res_ovf", 32'(res_ovf), 32'd0);
        chk("mid_rst_res_data", 32'(res_data), 32'd0);
        in_valid = 1'b0;
        in_a     = 8'h00;
        in_b     = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        beat_a[0] = 8'd3; beat_b[0] = 8'd3;
        exp_q.push_back({1'b0, 16'h0009});
        send_job(4'd1, 1, 0);
        check_drain_latency();
        wait_drain();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
